// File: rtl/msort_pkg.sv
// Shared types and helpers for the merge-sort tree sequencer.
package msort_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MERGE,
      DRAIN,
      DONE,
      ERR
   } state_t;

   // Bits needed to hold any count from 0 up to and including max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/msort_tree_ctrl_if.sv
// Input stream, FIFO/fifoMerge tree and output stream signals of the sort sequencer.
interface msort_tree_ctrl_if
   import msort_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int LEAVES = 4
);
   logic              in_valid;
   logic [WIDTH-1:0]  in_data;
   logic              in_last;
   logic              in_ready;

   logic [LEAVES-1:0] leaf_push_n;
   logic [WIDTH-1:0]  leaf_data;
   logic [LEAVES-1:0] leaf_full;
   logic              merge_en;
   logic              root_empty;
   logic [WIDTH-1:0]  root_data;
   logic              root_pop_n;

   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_ready;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready,
      output leaf_push_n, leaf_data,
      input  leaf_full,
      output merge_en,
      input  root_empty, root_data,
      output root_pop_n,
      output out_valid, out_data,
      input  out_ready
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready,
      input  leaf_push_n, leaf_data,
      output leaf_full,
      input  merge_en,
      output root_empty, root_data,
      input  root_pop_n,
      input  out_valid, out_data,
      output out_ready
   );
endinterface

// File: rtl/msort_order_chk.sv
// Non-decreasing order checker: pulses o_viol when a word is below its predecessor.
// Built only when MSORT_ORDER_CHECK_EN is defined.
`ifdef MSORT_ORDER_CHECK_EN
module msort_order_chk
   import msort_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             i_clr,
   input  logic             i_valid,
   input  logic             i_last,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_viol
);
   logic             r_first;
   logic [WIDTH-1:0] r_prev;

   assign o_viol = i_valid & ~r_first & (i_data < r_prev);

   // i_last re-arms the first-word flag so the next word starts a fresh run.
   always_ff @(posedge clk) begin
      if (srst || i_clr) begin
         r_first <= 1'b1;
         r_prev  <= '0;
      end else if (i_valid) begin
         r_first <= i_last;
         r_prev  <= i_data;
      end
   end
endmodule
`endif

// File: rtl/msort_tree_ctrl.sv
// Merge-sort tree sequencer: loads one presorted run per leaf FIFO, merges, drains the root.
// Define MSORT_ORDER_CHECK_EN to add input/output ordering checks.
module msort_tree_ctrl
   import msort_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LEAVES     = 4,
   parameter int LEAF_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   msort_tree_ctrl_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int CW = (LEAVES > 1) ? $clog2(LEAVES) : 1;
   localparam int RW = cnt_width(LEAF_DEPTH);
   localparam int TW = cnt_width(LEAVES * LEAF_DEPTH);
   localparam int IW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LAST_LEAF = CW'(LEAVES - 1);
   localparam logic [RW-1:0] RUN_MAX   = RW'(LEAF_DEPTH);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT - 1);

   state_t            r_state;
   logic [CW-1:0]     r_cur;
   logic [RW-1:0]     r_run_cnt;
   logic [TW-1:0]     r_total_cnt;
   logic [TW-1:0]     r_out_cnt;
   logic [IW-1:0]     r_idle_cnt;
   logic [LEAVES-1:0] r_push_n;
   logic [WIDTH-1:0]  r_leaf_data;
   logic              r_merge_en;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic w_in_ready, w_accept, w_run_close, w_overflow;
   logic w_drain, w_out_valid, w_hs, w_out_last, w_timeout;
   logic w_job_start, w_in_viol, w_out_viol, w_fail;

   assign w_in_ready  = (r_state == LOAD) && (r_run_cnt < RUN_MAX);
   assign w_accept    = bus.in_valid & w_in_ready;
   assign w_run_close = w_accept & (bus.in_last | ((r_run_cnt + RW'(1)) == RUN_MAX));
   assign w_overflow  = (r_state == LOAD) & bus.leaf_full[r_cur];
   assign w_drain     = (r_state == DRAIN);
   assign w_out_valid = w_drain & ~bus.root_empty;
   assign w_hs        = w_out_valid & bus.out_ready;
   assign w_out_last  = (r_out_cnt + TW'(1)) == r_total_cnt;
   // Fires on the TIMEOUT-th consecutive empty DRAIN cycle.
   assign w_timeout   = w_drain & bus.root_empty & (r_idle_cnt == IDLE_MAX);
   assign w_job_start = start & ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
   assign w_fail      = ((r_state == LOAD) & (w_overflow | w_in_viol)) |
                        (w_drain & (w_timeout | w_out_viol));

`ifdef MSORT_ORDER_CHECK_EN
   msort_order_chk #(.WIDTH(WIDTH)) u_in_chk (
      .clk(clock), .srst(reset), .i_clr(w_job_start), .i_valid(w_accept),
      .i_last(w_run_close), .i_data(bus.in_data), .o_viol(w_in_viol)
   );
   msort_order_chk #(.WIDTH(WIDTH)) u_out_chk (
      .clk(clock), .srst(reset), .i_clr(w_job_start), .i_valid(w_hs),
      .i_last(1'b0), .i_data(bus.root_data), .o_viol(w_out_viol)
   );
`else
   assign w_in_viol  = 1'b0;
   assign w_out_viol = 1'b0;
`endif

   assign bus.in_ready    = w_in_ready;
   assign bus.leaf_push_n = r_push_n;
   assign bus.leaf_data   = r_leaf_data;
   assign bus.merge_en    = r_merge_en;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_data    = w_drain ? bus.root_data : '0;
   assign bus.root_pop_n  = ~w_hs;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_run_cnt   <= '0;
         r_total_cnt <= '0;
         r_out_cnt   <= '0;
         r_idle_cnt  <= '0;
         r_push_n    <= '1;
         r_leaf_data <= '0;
         r_merge_en  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         // A push is a one-cycle pulse issued the cycle after its accept.
         r_push_n <= '1;
         if (w_fail) begin
            r_state    <= ERR;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_merge_en <= 1'b0;
         end else begin
            case (r_state)
               IDLE, DONE, ERR: begin
                  if (w_job_start) begin
                     r_state     <= LOAD;
                     r_busy      <= 1'b1;
                     r_done      <= 1'b0;
                     r_err       <= 1'b0;
                     r_cur       <= '0;
                     r_run_cnt   <= '0;
                     r_total_cnt <= '0;
                     r_out_cnt   <= '0;
                     r_idle_cnt  <= '0;
                  end
               end
               LOAD: begin
                  if (w_accept) begin
                     r_push_n[r_cur] <= 1'b0;
                     r_leaf_data     <= bus.in_data;
                     r_total_cnt     <= r_total_cnt + TW'(1);
                     if (w_run_close) begin
                        r_run_cnt <= '0;
                        if (r_cur == LAST_LEAF) begin
                           r_state    <= MERGE;
                           r_merge_en <= 1'b1;
                        end else begin
                           r_cur <= r_cur + CW'(1);
                        end
                     end else begin
                        r_run_cnt <= r_run_cnt + RW'(1);
                     end
                  end
               end
               MERGE: begin
                  r_state    <= DRAIN;
                  r_idle_cnt <= '0;
               end
               DRAIN: begin
                  r_idle_cnt <= bus.root_empty ? (r_idle_cnt + IW'(1)) : '0;
                  if (w_hs) begin
                     r_out_cnt <= r_out_cnt + TW'(1);
                     if (w_out_last) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_merge_en <= 1'b0;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule
